// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for the stream arbiter.
package rr_arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid searching ptr+1, ptr+2, ... modulo num_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num_req
    );
        rr_pick_t           res;
        logic [MAX_IDX_W:0] cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (!res.found && (k <= num_req)) begin
                cand = (MAX_IDX_W+1)'(ptr) + (MAX_IDX_W+1)'(k);
                // ptr < num_req and k <= num_req, so one subtraction wraps.
                if (32'(cand) >= num_req) begin
                    cand = cand - (MAX_IDX_W+1)'(num_req);
                end
                if (valid[cand[MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slice: 1-cycle latency, full throughput.
module stream_reg_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // A load wins over a drain; otherwise hold while stalled.
    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin N:1 valid/ready stream arbiter with per-packet locking and a
// registered output slice.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [IDX_W-1:0]              out_src,
    output logic                          busy
);

    localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1 + IDX_W;

    arb_state_e      state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    rr_pick_t              pick;
    logic                  unused_pick;
    logic [IDX_W-1:0]      winner;
    logic                  grant_ok;
    logic                  slice_ready;
    logic                  accept;
    logic                  acc_last;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [PAYLOAD_W-1:0]  slice_in;
    logic [PAYLOAD_W-1:0]  slice_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Winner selection: the locked source ignores in_valid, otherwise round-robin.
    always_comb begin
        pick     = rr_pick(MAX_REQ'(in_valid), MAX_IDX_W'(rr_ptr_q), NUM_REQ);
        winner   = (state_q == LOCKED) ? lock_idx_q : IDX_W'(pick.idx);
        grant_ok = (state_q == LOCKED) || pick.found;
        accept   = grant_ok && slice_ready && in_valid[winner];
        acc_last = in_last[winner];
        acc_data = in_data[winner*DATA_WIDTH +: DATA_WIDTH];
    end

    assign unused_pick = ^pick.idx;

    // Next-state: lock on a non-last beat, rotate priority on a last beat.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_last) begin
                        rr_ptr_d = winner;
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = winner;
                    end
                end
            end
            LOCKED: begin
                if (accept && acc_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = lock_idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-hot ready toward the winner only.
    always_comb begin
        in_ready = '0;
        if (slice_ready && grant_ok && ((state_q == LOCKED) || in_valid[winner])) begin
            in_ready[winner] = 1'b1;
        end
        busy = (state_q == LOCKED) || out_valid;
    end

    assign slice_in = {acc_data, acc_last, winner};

    stream_reg_slice #(
        .WIDTH (PAYLOAD_W)
    ) u_out_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_ready  (slice_ready),
        .in_data   (slice_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (slice_out)
    );

    assign out_data = slice_out[PAYLOAD_W-1 -: DATA_WIDTH];
    assign out_last = slice_out[IDX_W];
    assign out_src  = slice_out[IDX_W-1:0];

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: scoreboard of expected output beats
// plus direct checks of handshakes, stall stability and reset behaviour.
module tb_rr_stream_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  src;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-source instance
    logic [3:0]   in_valid, in_ready, in_last;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_last, busy;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    // 3-source instance
    logic [2:0]   v3, r3, l3;
    logic [95:0]  d3;
    logic         ov3, or3, ol3, busy3;
    logic [31:0]  od3;
    logic [1:0]   os3;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    beat_t       sb[$];
    logic [31:0] base[4];
    int          cnt[4];
    logic [31:0] hold_data;

    rr_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_src(out_src), .busy(busy)
    );

    rr_stream_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_ready(r3), .in_data(d3), .in_last(l3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3),
        .out_last(ol3), .out_src(os3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check in_ready, and queue the beats that must be accepted.
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                       input logic [3:0] exp_rdy, input string tag);
        beat_t b;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base[i] + 32'(cnt[i]);
        #1;
        chk(tag, 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && exp_rdy[i]) begin
                b.data = base[i] + 32'(cnt[i]);
                b.last = l[i];
                b.src  = 2'(i);
                sb.push_back(b);
                cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every completed output handshake must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL unexpected_beat: observed %0h expected none", {out_data, out_last, out_src});
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("out_beat", 64'({out_data, out_last, out_src}), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        v3 = '0; l3 = 3'b111; or3 = 1'b1;
        d3 = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
        for (int i = 0; i < 4; i++) begin
            base[i] = 32'((i + 1) << 28);
            cnt[i]  = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_src",   64'(out_src),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All sources valid, single-beat packets: grants 0,1,2,3,0
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, "t1_g0");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010, "t1_g1");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0100, "t1_g2");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b1000, "t1_g3");
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, "t1_g0b");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "t1_idle");

        // Source 2 three-beat packet locks out source 1
        base[2] = 32'h0000_00A0;
        cnt[2]  = 0;
        cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, "t2_b0");
        chk("t2_busy", 64'(busy), 64'd1);
        cyc(4'b0110, 4'b0010, 1'b1, 4'b0100, "t2_b1");
        cyc(4'b0110, 4'b0110, 1'b1, 4'b0100, "t2_b2");
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, "t2_src1");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "t2_idle");

        // Locked source 0 pauses while source 3 waits
        cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, "t3_lock0");
        cyc(4'b1000, 4'b1000, 1'b1, 4'b0001, "t3_gap0");
        chk("t3_drained", 64'(out_valid), 64'd0);
        chk("t3_busy",    64'(busy),      64'd1);
        cyc(4'b1000, 4'b1000, 1'b1, 4'b0001, "t3_gap1");
        cyc(4'b1001, 4'b0001, 1'b1, 4'b0001, "t3_end0");
        cyc(4'b1000, 4'b1000, 1'b1, 4'b1000, "t3_src3");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "t3_idle");

        // Back-pressure: 5 stalled cycles with a full slice
        hold_data = base[1] + 32'(cnt[1]);
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, "t4_load");
        for (int s = 0; s < 5; s++) begin
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_data",  64'(out_data),  64'(hold_data));
            chk("t4_hold_last",  64'(out_last),  64'd1);
            chk("t4_hold_src",   64'(out_src),   64'd1);
            cyc(4'b0100, 4'b0100, 1'b0, 4'b0000, "t4_stall_rdy");
        end
        cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, "t4_release");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "t4_idle");

        // Reset in the middle of a 4-beat packet from source 1
        cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, "t5_b0");
        out_ready = 1'b0;
        in_data[32 +: 32] = base[1] + 32'(cnt[1]);
        #1;
        chk("t5_b1_stalled", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy",  64'(busy),      64'd0);
        sb.delete();
        cnt[1] = 0;
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'b1000, 4'b1000, 1'b1, 4'b1000, "t5_src3_first");
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "t5_idle");

        // Three-source wrap: after source 2 wins, rr_ptr=2 so source 1 beats 2
        v3 = 3'b100;
        #1;
        chk("t6_rdy_src2", 64'(r3), 64'b100);
        @(posedge clk);
        #1;
        chk("t6_out_src2",  64'(os3), 64'd2);
        chk("t6_out_data2", 64'(od3), 64'h3000_0002);
        v3 = 3'b110;
        #1;
        chk("t6_rdy_wrap", 64'(r3), 64'b010);
        @(posedge clk);
        #1;
        chk("t6_out_src1",  64'(os3), 64'd1);
        chk("t6_out_data1", 64'(od3), 64'h3000_0001);
        chk("t6_out_valid", 64'(ov3), 64'd1);
        v3 = 3'b000;
        @(posedge clk);
        #1;

        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "end_idle");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Shares one valid/ready output stream between NUM_REQ valid/ready requesters.
- Uses round-robin arbitration with packet locking: once a source wins, it owns the output until its last beat is accepted.
- The output is registered through a single-entry register slice: 1-cycle latency, full throughput.
- Sits in front of a shared downstream pipeline stage or consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat.
- IDX_W, $clog2(NUM_REQ), source index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  NUM_REQ  per-source beat valid.
- in_ready  out  NUM_REQ  per-source beat accept.
- in_data  in  NUM_REQ*DATA_WIDTH  per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_REQ  per-source end-of-packet flag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  output payload.
- out_last  out  1  output end-of-packet flag.
- out_src  out  IDX_W  index of the source of the current output beat.
- busy  out  1  high when state is LOCKED or out_valid is high.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0, busy=0.
  - state=IDLE, rr_ptr=NUM_REQ-1, so source 0 has the highest priority first.
- Reset mid-packet: the lock and any slice contents are discarded. No beat is emitted. Upstream restarts its packets after reset.
- Register slice:
  - slice_ready = !out_valid || out_ready.
  - A transfer into the slice loads data, last and src, and sets out_valid.
  - Otherwise, out_ready&&out_valid clears out_valid.
  - Outputs stay stable while out_valid && !out_ready.
- Pick (combinational):
  - In IDLE, the winner is the first i with in_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - In LOCKED, the winner is lock_idx, regardless of in_valid.
- Handshake:
  - in_ready[i] = slice_ready && (i == winner) && (state==LOCKED || in_valid[i]).
  - At most one in_ready bit is set per cycle.
  - in_ready may depend on in_valid. Upstream valid must not depend on ready.
- Accept: a beat is accepted when in_valid[g]&&in_ready[g]. The slice loads in_data[g], in_last[g] and g.
- State machine:
  - IDLE, accept with last=0: go to LOCKED, lock_idx=g.
  - IDLE, accept with last=1 (single-beat packet): stay in IDLE, rr_ptr=g.
  - LOCKED, accept with last=1: go to IDLE, rr_ptr=lock_idx.
  - LOCKED, accept with last=0: stay in LOCKED.
  - LOCKED, locked source deasserts valid: stay in LOCKED and grant no other source.
- rr_ptr updates only on acceptance of a last beat.
- Latency: an input beat appears on the output the cycle after acceptance.
- Throughput: one beat per cycle sustained, including back-to-back packets from different sources (no idle bubble).
- No valid inputs: no in_ready, state unchanged.
- Back-pressure: out_ready=0 with a full slice drops all in_ready. Arbitration resumes when the slice drains.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum {IDLE, LOCKED}.
  - Function rr_pick(valid, ptr) returning winner index and found flag.
- Sub-module stream_reg_slice (DATA_WIDTH+1+IDX_W wide payload, single entry, ready = !valid || out_ready).
  - Instantiated once on the output; it is reusable elsewhere.

Test Plan:
- Reset, then in_valid=4'b1111 with all single-beat packets and out_ready=1 -> grant order 0,1,2,3,0; out_src sequence matches with 1-cycle latency; one beat per cycle.
- Source 2 sends a 3-beat packet (data 0xA0,0xA1,0xA2, last on the third) while source 1 is valid throughout -> the output shows 0xA0,0xA1,0xA2 with out_src=2, then source 1 wins; in_ready[1]=0 during the lock.
- In LOCKED on source 0, source 0 drops valid for 2 cycles while source 3 is valid -> no beats are accepted, out_valid goes 0 after drain, and the lock is held; source 0 resumes and completes its packet.
- out_ready held 0 for 5 cycles with a full slice -> out_data, out_last and out_src stay stable; all in_ready=0; on release the next beat follows with no loss or duplication.
- rst_n asserted during beat 2 of a 4-beat packet from source 1 -> out_valid=0 immediately, busy=0, state IDLE; after release with only source 3 valid, source 3 is granted first.
- NUM_REQ=3, sources 1 and 2 valid and rr_ptr=2 after the last grant -> source 1 wins next, confirming the wrap from the last index.
